// File: rtl/param_stream_router_if.sv
// Handshake bundle for the router: parameter-stream input and prediction-result output.
interface param_stream_router_if #(
  parameter int WIDTH_P = 32,
  parameter int WIDTH_O = 10
) ();
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH_P-1:0] i_tdata;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH_O-1:0] o_tdata;

  modport slave  (input  i_valid, i_tdata, i_ready, output o_ready, o_valid, o_tdata);
  modport master (output i_valid, i_tdata, i_ready, input  o_ready, o_valid, o_tdata);
endinterface

// File: rtl/param_stream_router.sv
// Framed parameter-stream decoder delivering assembled parameters to one-hot sinks,
// plus a small prediction FIFO returned on a valid/ready port.
module param_stream_router #(
  parameter int WIDTH_P   = 32,
  parameter int PARAM_W   = 60,
  parameter int N_DEST    = 85,
  parameter int WIDTH_O   = 10,
  parameter int RES_DEPTH = 4
) (
  input  logic                i_sclk,
  input  logic                i_rstp,
  param_stream_router_if.slave s,
  output logic [N_DEST-1:0]   o_param_vld,
  output logic [PARAM_W-1:0]  o_param,
  output logic                o_err,
  input  logic                i_predict_vld,
  input  logic [WIDTH_O-1:0]  i_predict,
  output logic                o_ovf
);
  localparam int WPP = (PARAM_W + WIDTH_P - 1) / WIDTH_P;
  localparam int WW  = $clog2(WPP + 1);
  localparam int AW  = $clog2(RES_DEPTH);

  typedef enum logic {HDR, PAY} state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        w_q, w_d;
  logic [15:0]          k_q, k_d, n_q, n_d;
  logic [7:0]           dest_q, dest_d;
  logic [PARAM_W-1:0]   asm_q, asm_d, param_q, param_d;
  logic [N_DEST-1:0]    vld_q, vld_d;
  logic                 err_q, err_d;
  logic [WPP*WIDTH_P-1:0] wide;
  logic                 unused_pad;
  logic                 accept, hdr_ok;

  assign accept = s.i_valid && s.o_ready;
  assign hdr_ok = (s.i_tdata[31:24] == 8'hA5) &&
                  ({24'd0, s.i_tdata[23:16]} < 32'(N_DEST)) &&
                  (s.i_tdata[15:0] != 16'd0);
  // Last-word bits beyond PARAM_W are dropped here.
  assign unused_pad = ^wide;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    n_d     = n_q;
    dest_d  = dest_q;
    asm_d   = asm_q;
    param_d = param_q;
    vld_d   = '0;
    err_d   = 1'b0;
    wide    = '0;
    wide[PARAM_W-1:0] = asm_q;
    if (accept) begin
      case (state_q)
        HDR: begin
          if (hdr_ok) begin
            dest_d  = s.i_tdata[23:16];
            n_d     = s.i_tdata[15:0];
            w_d     = '0;
            k_d     = '0;
            state_d = PAY;
          end else begin
            err_d = 1'b1;
          end
        end
        PAY: begin
          wide[w_q*WIDTH_P +: WIDTH_P] = s.i_tdata;
          asm_d = wide[PARAM_W-1:0];
          if (w_q == WW'(WPP - 1)) begin
            param_d = asm_d;
            for (int i = 0; i < N_DEST; i++) vld_d[i] = (dest_q == 8'(i));
            w_d = '0;
            k_d = k_q + 16'd1;
            if (k_q + 16'd1 == n_q) state_d = HDR;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rstp) begin
      state_q <= HDR;
      w_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      dest_q  <= '0;
      asm_q   <= '0;
      param_q <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      n_q     <= n_d;
      dest_q  <= dest_d;
      asm_q   <= asm_d;
      param_q <= param_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign o_param_vld = vld_q;
  assign o_param     = param_q;
  assign o_err       = err_q;
  assign s.o_ready   = !i_rstp;

  logic [WIDTH_O-1:0] mem_q [RES_DEPTH];
  logic [WIDTH_O-1:0] mem_d [RES_DEPTH];
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic               ovf_q, ovf_d;
  logic               empty, full, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && s.i_ready;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign push_ok = i_predict_vld && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = i_predict;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop) rd_d = rd_q + (AW+1)'(1);
    if (i_predict_vld && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge i_sclk) begin
    if (i_rstp) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  assign s.o_valid = !empty;
  assign s.o_tdata = mem_q[rd_q[AW-1:0]];
  assign o_ovf     = ovf_q;
endmodule

// File: tb/tb_param_stream_router.sv
// Directed bench for param_stream_router: frame decode, header rejection, reset, gaps, FIFO.
module tb_param_stream_router;
  localparam int WIDTH_P = 32, PARAM_W = 60, N_DEST = 85, WIDTH_O = 10, RES_DEPTH = 4;

  logic i_sclk = 1'b0;
  logic i_rstp;
  logic [N_DEST-1:0]  o_param_vld;
  logic [PARAM_W-1:0] o_param;
  logic o_err, i_predict_vld, o_ovf;
  logic [WIDTH_O-1:0] i_predict;

  param_stream_router_if #(.WIDTH_P(WIDTH_P), .WIDTH_O(WIDTH_O)) bus ();

  param_stream_router #(.WIDTH_P(WIDTH_P), .PARAM_W(PARAM_W), .N_DEST(N_DEST),
                        .WIDTH_O(WIDTH_O), .RES_DEPTH(RES_DEPTH)) dut (
    .i_sclk(i_sclk), .i_rstp(i_rstp), .s(bus.slave),
    .o_param_vld(o_param_vld), .o_param(o_param), .o_err(o_err),
    .i_predict_vld(i_predict_vld), .i_predict(i_predict), .o_ovf(o_ovf));

  always #5 i_sclk = ~i_sclk;

  int n_chk = 0, n_err = 0;
  int err_cnt = 0;
  logic [N_DEST-1:0]  q_vld [$];
  logic [PARAM_W-1:0] q_par [$];

  always @(negedge i_sclk) begin
    if (o_param_vld != '0) begin
      q_vld.push_back(o_param_vld);
      q_par.push_back(o_param);
    end
    if (o_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sclk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.i_valid = 1'b1; bus.i_tdata = w; step(); bus.i_valid = 1'b0;
  endtask

  task automatic clear_mon();
    q_vld.delete(); q_par.delete(); err_cnt = 0;
  endtask

  task automatic do_reset();
    i_rstp = 1'b1; step(); i_rstp = 1'b0;
  endtask

  task automatic push(input logic [WIDTH_O-1:0] v);
    i_predict_vld = 1'b1; i_predict = v; step(); i_predict_vld = 1'b0;
  endtask

  task automatic frame3(input bit gap);
    logic [31:0] words [7];
    words = '{32'hA504_0003, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    foreach (words[i]) begin
      send(words[i]);
      if (gap) step();
    end
    step(); step();
  endtask

  function automatic logic [127:0] oh(input int d);
    logic [127:0] one;
    one = 128'd1;
    return one << d;
  endfunction

  initial begin
    logic [PARAM_W-1:0] exp_p [3];
    exp_p = '{60'h0_0000_000B_0000_000A, 60'h0_0000_000D_0000_000C, 60'h0_0000_000F_0000_000E};
    i_rstp = 1'b1; bus.i_valid = 1'b0; bus.i_tdata = '0; bus.i_ready = 1'b0;
    i_predict_vld = 1'b0; i_predict = '0;
    step(); step();
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_tdata", bus.o_tdata, 0);
    chk("rst_param", o_param, 0);
    chk("rst_pvld", o_param_vld, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ovf", o_ovf, 0);
    i_rstp = 1'b0; #1;
    chk("ready_up", bus.o_ready, 1);

    // Two-parameter frame to sink 3
    clear_mon();
    send(32'hA503_0002); send(32'd1); send(32'd2);
    chk("t1_lat_vld", o_param_vld, oh(3));
    chk("t1_lat_par", o_param, 60'h0_0000_0002_0000_0001);
    send(32'd3); send(32'd4); step(); step();
    chk("t1_hold_par", o_param, 60'h0_0000_0004_0000_0003);
    chk("t1_cnt", q_vld.size(), 2);
    if (q_vld.size() == 2) begin
      chk("t1_v0", q_vld[0], oh(3));
      chk("t1_p0", q_par[0], 60'h0_0000_0002_0000_0001);
      chk("t1_v1", q_vld[1], oh(3));
      chk("t1_p1", q_par[1], 60'h0_0000_0004_0000_0003);
    end

    // Rejected headers, then a good one
    clear_mon();
    send(32'h5503_0001);
    chk("t2_err_lat", o_err, 1);
    send(32'hA555_0001); send(32'hA500_0000); step(); step();
    chk("t2_err_cnt", err_cnt, 3);
    chk("t2_no_strobe", q_vld.size(), 0);
    send(32'hA502_0001); send(32'd5); send(32'd6); step();
    chk("t2_cnt", q_vld.size(), 1);
    if (q_vld.size() == 1) begin
      chk("t2_v", q_vld[0], oh(2));
      chk("t2_p", q_par[0], 60'h0_0000_0006_0000_0005);
    end

    // Reset mid-frame discards the partial parameter
    clear_mon();
    send(32'hA503_0001); send(32'h11);
    i_rstp = 1'b1; #1;
    chk("t3_ready_rst", bus.o_ready, 0);
    step(); i_rstp = 1'b0;
    chk("t3_param_rst", o_param, 0);
    send(32'hA501_0001); send(32'd7); send(32'd8); step();
    chk("t3_cnt", q_vld.size(), 1);
    if (q_vld.size() == 1) begin
      chk("t3_v", q_vld[0], oh(1));
      chk("t3_p", q_par[0], 60'h0_0000_0008_0000_0007);
    end

    // Gap-free vs gapped 3-parameter frame
    for (int g = 0; g < 2; g++) begin
      clear_mon();
      frame3(g != 0);
      chk($sformatf("t4_cnt_g%0d", g), q_vld.size(), 3);
      if (q_vld.size() == 3)
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("t4_v%0d_g%0d", i, g), q_vld[i], oh(4));
          chk($sformatf("t4_p%0d_g%0d", i, g), q_par[i], exp_p[i]);
        end
    end

    // FIFO overflow
    bus.i_ready = 1'b0;
    for (int v = 1; v <= 4; v++) push(WIDTH_O'(v));
    chk("t5_ovf_full", o_ovf, 0);
    push(10'd5);
    chk("t5_valid", bus.o_valid, 1);
    chk("t5_head", bus.o_tdata, 1);
    chk("t5_ovf", o_ovf, 1);
    bus.i_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("t5_pop%0d", v), bus.o_tdata, v);
      step();
    end
    chk("t5_empty", bus.o_valid, 0);
    bus.i_ready = 1'b0;

    // Push and pop together while full
    do_reset();
    chk("t6_ovf_clr", o_ovf, 0);
    for (int v = 5; v <= 8; v++) push(WIDTH_O'(v));
    chk("t6_head", bus.o_tdata, 5);
    bus.i_ready = 1'b1;
    push(10'd9);
    chk("t6_ovf", o_ovf, 0);
    for (int v = 6; v <= 9; v++) begin
      chk($sformatf("t6_pop%0d", v), bus.o_tdata, v);
      step();
    end
    chk("t6_empty", bus.o_valid, 0);
    push(10'd3);
    chk("t6_empty_push", bus.o_tdata, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
